inst_queue: RTL
===============

# inst_queue

Decoupling FIFO between the fetch stage and decode. Each entry holds one instruction word and its `pc_n` (the PC of the following instruction).
- Fetch pushes one entry per cycle while the queue has room.
- Decode pops from the head with a valid/ready handshake.
- A jump flush discards every queued entry, so no wrong-path instructions reach decode.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `CW`, default `$clog2(DEPTH)+1`: width of the occupancy count.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: fetch presents an entry this cycle.
- `in_pc_n`, input, 32: `pc_n` from fetch.
- `in_inst`, input, 32: instruction word from fetch.
- `in_ready`, output, 1: the queue can accept a push this cycle. Fetch uses it as its stall.
- `flush`, input, 1: discard all entries. Driven by the jump-taken signal (`isjmp`).
- `out_valid`, output, 1: the head entry is valid.
- `out_pc_n`, output, 32: `pc_n` of the head entry.
- `out_inst`, output, 32: instruction word of the head entry.
- `out_ready`, input, 1: decode accepts the head entry this cycle.
- `count`, output, CW: current occupancy, 0 to DEPTH.

## Operation
State:
- Write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits, wrapping modulo DEPTH.
- Occupancy counter `count`.
- Storage array of DEPTH × 64 bits, holding `{pc_n, inst}` per entry.

Handshake:
- `push = in_valid & in_ready & ~flush`.
- `pop = out_valid & out_ready & ~flush`.
- `in_ready = (count != DEPTH)`. It depends only on registered state. There is no full-bypass: when the queue is full, `in_ready` stays 0 even if `out_ready` is 1 in the same cycle.
- `out_valid = (count != 0)`. There is no empty-bypass: a push into an empty queue is not visible on the outputs until the next cycle.

Data path:
- `out_pc_n` and `out_inst` read the entry at `rp` combinationally.
- When `count == 0`, both outputs are forced to 0.

Update on the clock edge:
- push only: write the entry at `wp`, `wp+1`, `count+1`.
- pop only: `rp+1`, `count-1`.
- push and pop together: write at `wp`, `wp+1`, `rp+1`, `count` unchanged.
- `flush`: `wp=0`, `rp=0`, `count=0`. The storage array is untouched. Flush overrides any push or pop in the same cycle, so the entry fetch presents during the flush cycle is dropped.

Additional rules:
- Entries are stored without interpretation. A 32'h00000000 NOP occupies a slot like any other instruction.
- Reset has priority over everything. Asserting `rst_n=0` mid-operation immediately sets `wp=0`, `rp=0`, `count=0`. The storage array has no reset.

## Timing
Reset values:
- `count=0`
- `out_valid=0`
- `out_pc_n=0`
- `out_inst=0`
- `in_ready=1`

Latency and throughput:
- Push-to-visible latency is 1 cycle: an entry pushed at edge N appears on the outputs after edge N (`out_valid=1` when the queue was empty).
- Sustained throughput is 1 push and 1 pop per cycle whenever `0 < count < DEPTH`.

Flush:
- `flush` sampled high at edge N means `out_valid=0` and `in_ready=1` after edge N.
- Fetch presents the jump target at edge N+1. It can therefore be pushed in the cycle after the flush.

Pointer wrap:
- `wp` and `rp` wrap from DEPTH-1 to 0 with no gap.
- Full and empty are decided only from `count`, never by comparing pointers.

## Test plan
1. Reset and fill:
   - Stimulus: hold `rst_n=0`, release, push 4 entries with `in_inst`=32'h05110003, 32'h055d0001, 32'h07b80000, 32'h00000000 and `pc_n`=1..4, with `out_ready=0`.
   - Required: after 4 edges `count=4`, `in_ready=0`, head=`{1, 32'h05110003}`. A 5th push is ignored.
2. Drain in order:
   - Stimulus: from full, `out_ready=1`, `in_valid=0`.
   - Required: heads appear in the order `pc_n`=1,2,3,4. Then `out_valid=0`, `out_inst=0`, `count=0`.
3. Streaming with wrap:
   - Stimulus: `in_valid=1` and `out_ready=1` for 10 cycles with `pc_n`=1..10.
   - Required: `count` holds at 1 after the first edge, and decode receives `pc_n` 1..10 in order across pointer wrap.
4. Full with pop:
   - Stimulus: queue full, `out_ready=1`, `in_valid=1`.
   - Required: `in_ready=0` in that cycle, only the pop occurs, `count` goes 4→3. On the next cycle the push is accepted.
5. Flush vs push:
   - Stimulus: `count=3`, then `flush=1`, `in_valid=1`, `in_pc_n`=32'h40 in the same cycle.
   - Required: after the edge, `count=0` and the 32'h40 entry is absent. A push of 32'h44 on the next cycle becomes the head.
6. Async reset mid-traffic:
   - Stimulus: `count=2`, drive `rst_n=0` between clock edges.
   - Required: `count=0`, `out_valid=0`, `in_ready=1` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for inst_queue: push side, pop side, flush and occupancy.
interface inst_queue_if #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
);
   logic          in_valid;
   logic [31:0]   in_pc_n;
   logic [31:0]   in_inst;
   logic          in_ready;
   logic          flush;
   logic          out_valid;
   logic [31:0]   out_pc_n;
   logic [31:0]   out_inst;
   logic          out_ready;
   logic [CW-1:0] count;

   modport master (
      output in_valid, in_pc_n, in_inst, flush, out_ready,
      input  in_ready, out_valid, out_pc_n, out_inst, count
   );

   modport slave (
      input  in_valid, in_pc_n, in_inst, flush, out_ready,
      output in_ready, out_valid, out_pc_n, out_inst, count
   );
endinterface

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO holding {pc_n, inst}; flush on a taken jump drops all entries.
// Full/empty come only from the occupancy counter, so pointers wrap freely.
module inst_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input logic         clk,
   input logic         rst_n,
   inst_queue_if.slave q
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;
   logic [63:0]   mem_q [DEPTH];
   logic          push, pop;
   logic          in_ready, out_valid;

   // Ready/valid depend only on registered occupancy: no full or empty bypass.
   assign in_ready    = (count_q != CW'(DEPTH));
   assign out_valid   = (count_q != '0);
   assign push        = q.in_valid & in_ready & ~q.flush;
   assign pop         = out_valid & q.out_ready & ~q.flush;

   assign q.in_ready  = in_ready;
   assign q.out_valid = out_valid;
   assign q.count     = count_q;
   assign q.out_pc_n  = out_valid ? mem_q[rp_q][63:32] : 32'd0;
   assign q.out_inst  = out_valid ? mem_q[rp_q][31:0]  : 32'd0;

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (q.flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (push) wp_d = wp_q + AW'(1);
         if (pop)  rp_d = rp_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; stale contents are masked by the counter.
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= {q.in_pc_n, q.in_inst};
   end
endmodule
